// File: rtl/bit_timer_frame.sv
// UART bit-period timer: bit_tick every k_act+1 clocks, mid-bit half_tick, and frame
// bit counting with a double-buffered divisor that only changes on bit boundaries.
module bit_timer_frame #(
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned BITS_W    = 4,
    parameter int unsigned DEFAULT_K = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [BITS_W-1:0] nbits,
    input  logic [CNT_W-1:0]  k,
    input  logic              k_load,
    output logic              busy,
    output logic              bit_tick,
    output logic              half_tick,
    output logic [BITS_W-1:0] bit_idx,
    output logic              frame_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  q_q;
    logic [CNT_W-1:0]  k_act_q;
    logic [CNT_W-1:0]  k_pend_q;
    logic              k_pend_vld_q;
    logic [BITS_W-1:0] bit_idx_q;
    logic [BITS_W-1:0] nbits_lat_q;

    logic running;
    logic period_end;
    logic last_bit;
    logic k_apply;

    assign running    = (state_q == RUN);
    assign period_end = running && !abort && (q_q == k_act_q);
    assign last_bit   = (bit_idx_q == nbits_lat_q - BITS_W'(1));
    // Divisor may only change between bit periods, or at any time while idle.
    assign k_apply    = !running || period_end;

    assign busy       = running;
    assign bit_tick   = period_end;
    assign half_tick  = running && !abort && (q_q == (k_act_q >> 1));
    assign frame_done = period_end && last_bit;
    assign bit_idx    = bit_idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            q_q          <= '0;
            k_act_q      <= CNT_W'(DEFAULT_K);
            k_pend_q     <= '0;
            k_pend_vld_q <= 1'b0;
            bit_idx_q    <= '0;
            nbits_lat_q  <= '0;
        end else begin
            // A load arriving on a boundary bypasses the pending slot so it is
            // visible to the very next bit, including the first bit of a frame.
            if (k_apply && k_load) begin
                k_act_q      <= k;
                k_pend_vld_q <= 1'b0;
            end else if (k_apply && k_pend_vld_q) begin
                k_act_q      <= k_pend_q;
                k_pend_vld_q <= 1'b0;
            end else if (k_load) begin
                k_pend_q     <= k;
                k_pend_vld_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start && !abort && (nbits != '0)) begin
                        state_q     <= RUN;
                        q_q         <= '0;
                        bit_idx_q   <= '0;
                        nbits_lat_q <= nbits;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        q_q       <= '0;
                        bit_idx_q <= '0;
                    end else if (period_end) begin
                        q_q <= '0;
                        if (last_bit) begin
                            state_q   <= IDLE;
                            bit_idx_q <= '0;
                        end else begin
                            bit_idx_q <= bit_idx_q + BITS_W'(1);
                        end
                    end else begin
                        q_q <= q_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_timer_frame.sv
// Bench for bit_timer_frame: vector table, directed multi-cycle sequences, and a
// random run checked against a bit-period reference model.
module tb_bit_timer_frame;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [3:0]  nbits;
    logic [19:0] k;
    logic        k_load;
    logic        busy;
    logic        bit_tick;
    logic        half_tick;
    logic [3:0]  bit_idx;
    logic        frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    bit_timer_frame #(.CNT_W(20), .BITS_W(4), .DEFAULT_K(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .nbits      (nbits),
        .k          (k),
        .k_load     (k_load),
        .busy       (busy),
        .bit_tick   (bit_tick),
        .half_tick  (half_tick),
        .bit_idx    (bit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // {busy, bit_tick, half_tick, frame_done, bit_idx}
    function automatic logic [7:0] obs();
        return {busy, bit_tick, half_tick, frame_done, bit_idx};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic [3:0] nb,
                         input logic [19:0] kk, input logic kl);
        @(negedge clk);
        start = s; abort = a; nbits = nb; k = kk; k_load = kl;
        #1;
    endtask

    typedef struct {
        logic        s;
        logic        a;
        logic [3:0]  nb;
        logic [19:0] kk;
        logic        kl;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model: a frame is a sequence of bit periods whose length is fixed
    // at the moment each bit begins.
    bit m_run;
    int m_pos, m_per, m_bit, m_nb, m_k, m_pend;
    bit m_vld;

    initial begin
        int tk[3];
        int nt;
        int done_c;

        reset = 1'b1; start = 0; abort = 0; nbits = 0; k = 0; k_load = 0;
        #1;
        chk("reset_state", obs(), 8'h00);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Vector table: one row per cycle, expectation sampled in that cycle.
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd3, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 4'd2, 20'd0, 1'b0, 8'h00}); // start, cyc0
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'h80});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'hA0});
        tbl.push_back('{1'b1, 1'b0, 4'd5, 20'd0, 1'b0, 8'h80}); // start while RUN
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'hC0});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'h81});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'hA1});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'h81});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'hD1});
        tbl.push_back('{1'b1, 1'b0, 4'd0, 20'd0, 1'b0, 8'h00}); // nbits=0 start
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b1, 8'h00}); // k=0
        tbl.push_back('{1'b1, 1'b0, 4'd3, 20'd0, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'hE0});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'hE1});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'hF2});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 4'd1, 20'd1, 1'b1, 8'h00}); // start+k_load
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'hA0});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'hD0});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 20'd0, 1'b0, 8'h00});
        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].a, tbl[i].nb, tbl[i].kk, tbl[i].kl);
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // k=9 frame, reload to 4 at q=5 of bit 0.
        tk = '{0, 0, 0}; nt = 0; done_c = 0;
        drive(0, 0, 0, 20'd9, 1);
        drive(1, 0, 4'd3, 20'd0, 0);
        for (int c = 1; c <= 21; c++) begin
            drive(0, 0, 0, (c == 6) ? 20'd4 : 20'd0, c == 6);
            if (bit_tick && nt < 3) begin
                tk[nt] = c;
                nt++;
            end
            if (frame_done) done_c = c;
        end
        chk("k9_tick0", tk[0], 10);
        chk("k9_tick1", tk[1], 15);
        chk("k9_tick2", tk[2], 20);
        chk("k9_done", done_c, 20);
        chk("k9_idle", obs(), 8'h00);

        // Abort at q=3 of bit 2 with k=7 (half_tick point, so masking is visible).
        drive(0, 0, 0, 20'd7, 1);
        drive(1, 0, 4'd8, 20'd0, 0);
        for (int c = 1; c <= 19; c++) drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        chk("abort_mask", obs(), 8'h82);
        drive(0, 0, 0, 0, 0);
        chk("abort_next", obs(), 8'h00);
        drive(1, 0, 4'd1, 20'd0, 0);
        for (int c = 1; c <= 8; c++) begin
            drive(0, 0, 0, 0, 0);
            if (c == 4) chk("post_abort_half", obs(), 8'hA0);
            if (c == 8) chk("post_abort_done", obs(), 8'hD0);
        end
        drive(0, 0, 0, 0, 0);
        chk("post_abort_idle", obs(), 8'h00);
        drive(1, 1, 4'd2, 20'd0, 0);
        drive(0, 0, 0, 0, 0);
        chk("abort_start_idle", obs(), 8'h00);

        // Async reset mid-frame with a pending divisor.
        drive(0, 0, 0, 20'd5, 1);
        drive(1, 0, 4'd4, 20'd0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("rst_pre_half", obs(), 8'hA0);
        drive(0, 0, 0, 20'd2, 1);
        drive(0, 0, 0, 0, 0);
        chk("rst_pre_busy", obs(), 8'h80);
        reset = 1'b1;
        #1;
        chk("rst_async", obs(), 8'h00);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 4'd1, 20'd0, 0);
        chk("rst_start", obs(), 8'h00);
        drive(0, 0, 0, 0, 0);
        chk("rst_default_k", obs(), 8'hF0);
        drive(0, 0, 0, 0, 0);
        chk("rst_idle", obs(), 8'h00);

        // Random run against the model.
        @(negedge clk);
        reset = 1'b1;
        m_run = 0; m_pos = 0; m_per = 1; m_bit = 0; m_nb = 0; m_k = 0; m_pend = 0; m_vld = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bit s, a, kl, e_tick, e_half, e_done, bnd;
            int nb, kk, e_idx;
            s  = ($urandom_range(3) == 0);
            a  = ($urandom_range(15) == 0);
            kl = ($urandom_range(7) == 0);
            nb = $urandom_range(4);
            kk = $urandom_range(6);
            drive(s, a, 4'(nb), 20'(kk), kl);

            e_tick = m_run && !a && (m_pos == m_per - 1);
            e_half = m_run && !a && (m_pos == (m_per - 1) / 2);
            e_done = e_tick && (m_bit == m_nb - 1);
            e_idx  = m_run ? m_bit : 0;
            chk("rand", obs(), {m_run, e_tick, e_half, e_done, 4'(e_idx)});

            bnd = !m_run || e_tick;
            if (bnd && kl) begin
                m_k = kk; m_vld = 0;
            end else if (bnd && m_vld) begin
                m_k = m_pend; m_vld = 0;
            end else if (kl) begin
                m_pend = kk; m_vld = 1;
            end
            if (!m_run) begin
                if (s && !a && nb != 0) begin
                    m_run = 1; m_pos = 0; m_bit = 0; m_nb = nb; m_per = m_k + 1;
                end
            end else if (a) begin
                m_run = 0;
            end else if (e_tick) begin
                if (e_done) m_run = 0;
                else begin
                    m_bit++; m_pos = 0; m_per = m_k + 1;
                end
            end else begin
                m_pos++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
